// File: rtl/fetch_byte_queue_pkg.sv
// fetch_byte_queue_pkg: shared types and defaults for the fetch byte queue
package fetch_byte_queue_pkg;
  typedef logic [63:0] reg_t;
  localparam int FETCH_BYTES_DEFAULT = 4;
  localparam int DEC_WINDOW_DEFAULT = 8;
  localparam int MAX_INST_LEN = 15;
  typedef logic [FETCH_BYTES_DEFAULT-1:0][7:0] fetch_word_t;
endpackage

// File: rtl/fetch_byte_queue_if.sv
// fetch_byte_queue_if: instruction memory request/return bus
interface fetch_byte_queue_if
  import fetch_byte_queue_pkg::*;
#(
  parameter int FETCH_BYTES = FETCH_BYTES_DEFAULT
) ();
  logic imem_req;
  reg_t imem_addr;
  logic [8*FETCH_BYTES-1:0] imem_rdata;
  logic imem_rvalid;
  modport master (output imem_req, imem_addr, input imem_rdata, imem_rvalid);
  modport slave (input imem_req, imem_addr, output imem_rdata, imem_rvalid);
endinterface

// File: rtl/fetch_byte_queue_byte_ring.sv
// fetch_byte_queue_byte_ring: circular byte store with multi-byte write at tail and window read at head
module fetch_byte_queue_byte_ring
  import fetch_byte_queue_pkg::*;
#(
  parameter int QUEUE_BYTES = 16,
  parameter int FETCH_BYTES = FETCH_BYTES_DEFAULT,
  parameter int DEC_WINDOW = DEC_WINDOW_DEFAULT
) (
  input  logic                                clk,
  input  logic                                wr_en,
  input  logic [$clog2(QUEUE_BYTES)-1:0]      wr_ptr,
  input  logic [$clog2(FETCH_BYTES+1)-1:0]    wr_cnt,
  input  logic [FETCH_BYTES-1:0][7:0]         wr_data,
  input  logic [$clog2(QUEUE_BYTES)-1:0]      rd_ptr,
  output logic [DEC_WINDOW-1:0][7:0]          rd_data
);
  localparam int QW = $clog2(QUEUE_BYTES);
  logic [7:0] mem [QUEUE_BYTES];
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_BYTES; i++)
      if (wr_en && i < int'(wr_cnt)) mem[wr_ptr + QW'(i)] <= wr_data[i];
  end
  for (genvar g = 0; g < DEC_WINDOW; g++) begin : g_rd
    assign rd_data[g] = mem[rd_ptr + QW'(g)];
  end
endmodule

// File: rtl/fetch_byte_queue.sv
// fetch_byte_queue: fetches aligned imem words into a byte queue and exposes a decode window
module fetch_byte_queue
  import fetch_byte_queue_pkg::*;
#(
  parameter int QUEUE_BYTES = 16,
  parameter int FETCH_BYTES = FETCH_BYTES_DEFAULT,
  parameter int DEC_WINDOW = DEC_WINDOW_DEFAULT,
  parameter int IMEM_LATENCY = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              redirect,
  input  reg_t                              redirect_pc,
  input  logic                              stall_pc,
  fetch_byte_queue_if.master                imem,
  output logic [8*DEC_WINDOW-1:0]           win_bytes,
  output logic [$clog2(DEC_WINDOW+1)-1:0]   win_cnt,
  output reg_t                              win_pc,
  input  logic                              consume,
  input  logic [3:0]                        consume_len
);
  localparam int QW = $clog2(QUEUE_BYTES);
  localparam int CW = $clog2(QUEUE_BYTES + 1);
  localparam int WW = $clog2(DEC_WINDOW + 1);
  localparam int IW = $clog2(IMEM_LATENCY + 1);
  localparam int SW = $clog2(FETCH_BYTES);
  localparam int NW = $clog2(FETCH_BYTES + 1);
  logic [QW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [IW-1:0] inflight;
  logic epoch, active, skip_pending;
  logic [SW-1:0] skip, wr_skip;
  reg_t fetch_addr;
  logic pipe_v [IMEM_LATENCY];
  logic pipe_e [IMEM_LATENCY];
  logic req, ret, wr_en, acc;
  logic [NW-1:0] wr_cnt;
  logic [FETCH_BYTES-1:0][7:0] wr_data;
  logic [DEC_WINDOW-1:0][7:0] rd_data;
  always_comb begin
    req = ~rst & active & ~redirect & (int'(count) + FETCH_BYTES * int'(inflight) <= QUEUE_BYTES - FETCH_BYTES);
    ret = imem.imem_rvalid & pipe_v[IMEM_LATENCY-1];
    wr_en = ret & ~redirect & (pipe_e[IMEM_LATENCY-1] == epoch);
    wr_skip = skip_pending ? skip : '0;
    wr_cnt = NW'(FETCH_BYTES) - NW'(wr_skip);
    wr_data = imem.imem_rdata >> {wr_skip, 3'b000};
    win_cnt = int'(count) >= DEC_WINDOW ? WW'(DEC_WINDOW) : WW'(count);
    acc = consume & ~stall_pc & ~redirect & (int'(consume_len) <= int'(win_cnt));
  end
  assign imem.imem_req = req;
  assign imem.imem_addr = fetch_addr;
  for (genvar g = 0; g < DEC_WINDOW; g++) begin : g_win
    assign win_bytes[8*g +: 8] = g < int'(win_cnt) ? rd_data[g] : 8'h00;
  end
  fetch_byte_queue_byte_ring #(
    .QUEUE_BYTES(QUEUE_BYTES),
    .FETCH_BYTES(FETCH_BYTES),
    .DEC_WINDOW(DEC_WINDOW)
  ) u_ring (
    .clk(clk),
    .wr_en(wr_en),
    .wr_ptr(tail),
    .wr_cnt(wr_cnt),
    .wr_data(wr_data),
    .rd_ptr(head),
    .rd_data(rd_data)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      inflight <= '0;
      epoch <= 1'b0;
      active <= 1'b0;
      skip_pending <= 1'b0;
      skip <= '0;
      fetch_addr <= '0;
      win_pc <= '0;
      for (int i = 0; i < IMEM_LATENCY; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_e[i] <= 1'b0;
      end
    end else begin
      pipe_v[0] <= req;
      pipe_e[0] <= epoch;
      for (int i = 1; i < IMEM_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_e[i] <= pipe_e[i-1];
      end
      inflight <= inflight + IW'(req) - IW'(ret);
      if (redirect) begin
        head <= '0;
        tail <= '0;
        count <= '0;
        win_pc <= redirect_pc;
        fetch_addr <= redirect_pc & ~reg_t'(FETCH_BYTES - 1);
        epoch <= ~epoch;
        active <= 1'b1;
        skip_pending <= 1'b1;
        skip <= redirect_pc[SW-1:0];
      end else begin
        if (req) fetch_addr <= fetch_addr + reg_t'(FETCH_BYTES);
        if (wr_en) begin
          tail <= tail + QW'(wr_cnt);
          skip_pending <= 1'b0;
        end
        if (acc) begin
          head <= head + QW'(consume_len);
          win_pc <= win_pc + reg_t'(consume_len);
        end
        count <= count + (wr_en ? CW'(wr_cnt) : CW'(0)) - (acc ? CW'(consume_len) : CW'(0));
      end
    end
  end
endmodule

// File: tb/tb_fetch_byte_queue.sv
// tb_fetch_byte_queue: random and directed stimulus against a byte-stream reference model
module tb_fetch_byte_queue;
  import fetch_byte_queue_pkg::*;
  logic clk = 1'b0;
  logic rst, redirect, stall_pc, consume;
  reg_t redirect_pc;
  logic [3:0] consume_len;
  logic [63:0] win_bytes;
  logic [3:0] win_cnt;
  reg_t win_pc;
  fetch_byte_queue_if imem ();
  fetch_byte_queue dut (
    .clk(clk),
    .rst(rst),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .stall_pc(stall_pc),
    .imem(imem),
    .win_bytes(win_bytes),
    .win_cnt(win_cnt),
    .win_pc(win_pc),
    .consume(consume),
    .consume_len(consume_len)
  );
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0] q [$];
  reg_t req_log [$];
  reg_t pc_log [$];
  reg_t m_pc = '0;
  reg_t m_fetch = '0;
  reg_t p_addr = '0;
  bit m_active = 1'b0;
  bit m_skip_pend = 1'b0;
  bit p_v = 1'b0;
  int m_skip = 0;
  int m_infl = 0;
  int m_gen = 0;
  int m_rgen = 0;
  int p_gen = 0;
  int p_rgen = 0;
  function automatic logic [7:0] byte_at(reg_t a);
    return a[7:0] ^ a[15:8];
  endfunction
  function automatic fetch_word_t word_at(reg_t a);
    fetch_word_t w;
    for (int k = 0; k < FETCH_BYTES_DEFAULT; k++) w[k] = byte_at(a + reg_t'(k));
    return w;
  endfunction
  function automatic int exp_cnt();
    return q.size() < 8 ? q.size() : 8;
  endfunction
  function automatic logic [63:0] exp_win();
    logic [63:0] w = '0;
    for (int k = 0; k < exp_cnt(); k++) w[8*k +: 8] = q[k];
    return w;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input bit r_i, input bit rd_i, input reg_t rpc_i, input bit st_i, input bit cn_i, input int len_i);
    bit mreq, acc, nv;
    reg_t na;
    int wc, pg, prg;
    rst = r_i;
    redirect = rd_i;
    redirect_pc = rpc_i;
    stall_pc = st_i;
    consume = cn_i;
    consume_len = 4'(len_i);
    imem.imem_rvalid = p_v;
    imem.imem_rdata = word_at(p_addr);
    #1;
    mreq = !r_i && m_active && !rd_i && (q.size() + 4 * m_infl <= 12);
    chk("imem_req", 64'(imem.imem_req), 64'(mreq));
    if (!r_i) chk("imem_addr", imem.imem_addr, m_fetch);
    nv = (imem.imem_req === 1'b1);
    na = imem.imem_addr;
    if (nv) req_log.push_back(na);
    pg = m_gen;
    prg = m_rgen;
    wc = exp_cnt();
    acc = cn_i && !st_i && !rd_i && len_i <= wc;
    if (r_i) begin
      q.delete();
      m_pc = '0;
      m_fetch = '0;
      m_active = 1'b0;
      m_skip_pend = 1'b0;
      m_infl = 0;
      m_gen++;
      m_rgen++;
    end else begin
      if (p_v && p_rgen == m_rgen) m_infl--;
      if (rd_i) begin
        q.delete();
        m_pc = rpc_i;
        m_fetch = rpc_i & ~reg_t'(3);
        m_gen++;
        m_active = 1'b1;
        m_skip_pend = 1'b1;
        m_skip = int'(rpc_i[1:0]);
      end else begin
        if (acc) begin
          repeat (len_i) void'(q.pop_front());
          m_pc += reg_t'(len_i);
        end
        if (p_v && p_gen == m_gen) begin
          for (int k = (m_skip_pend ? m_skip : 0); k < 4; k++) q.push_back(byte_at(p_addr + reg_t'(k)));
          m_skip_pend = 1'b0;
        end
        if (mreq) begin
          m_fetch += reg_t'(4);
          m_infl++;
        end
      end
    end
    p_v = nv;
    p_addr = na;
    p_gen = pg;
    p_rgen = prg;
    @(posedge clk);
    @(negedge clk);
    chk("win_cnt", 64'(win_cnt), 64'(exp_cnt()));
    chk("win_pc", win_pc, m_pc);
    chk("win_bytes", win_bytes, exp_win());
  endtask
  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1);
  endtask
  task automatic redir(input reg_t pc);
    step(1'b0, 1'b1, pc, 1'b0, 1'b0, 1);
  endtask
  initial begin
    bit found;
    int roll;
    reg_t rpc, saved_pc;
    logic [63:0] saved_w;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata = '0;
    @(negedge clk);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1);
    chk("reset_win_cnt", 64'(win_cnt), 64'd0);
    chk("reset_win_pc", win_pc, 64'd0);
    chk("reset_imem_addr", imem.imem_addr, 64'd0);
    idle();
    chk("reset_no_req", 64'(imem.imem_req), 64'd0);
    req_log.delete();
    redir(64'h1000);
    repeat (8) idle();
    chk("fill_req_count", 64'(req_log.size()), 64'd4);
    if (req_log.size() == 4) begin
      chk("fill_req0", req_log[0], 64'h1000);
      chk("fill_req3", req_log[3], 64'h100C);
    end
    chk("fill_win_cnt", 64'(win_cnt), 64'd8);
    chk("fill_byte0", 64'(win_bytes[7:0]), 64'h10);
    req_log.delete();
    redir(64'h1002);
    idle();
    idle();
    chk("skip_first_addr", req_log.size() > 0 ? req_log[0] : 64'hDEAD, 64'h1000);
    chk("skip_win_cnt", 64'(win_cnt), 64'd2);
    chk("skip_bytes", 64'(win_bytes[15:0]), 64'h1312);
    chk("skip_win_pc", win_pc, 64'h1002);
    redir(64'h1000);
    pc_log.delete();
    for (int c = 0; c < 30; c++) begin
      if (pc_log.size() == 0 || pc_log[$] != win_pc) pc_log.push_back(win_pc);
      step(1'b0, 1'b0, '0, 1'b0, 1'b1, 3);
    end
    chk("steady_pc_log_size", 64'(pc_log.size() >= 3), 64'd1);
    if (pc_log.size() >= 3) begin
      chk("steady_pc0", pc_log[0], 64'h1000);
      chk("steady_pc1", pc_log[1], 64'h1003);
      chk("steady_pc2", pc_log[2], 64'h1006);
    end
    saved_pc = m_pc;
    saved_w = exp_win();
    repeat (3) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b1, 3);
      chk("stall_pc_hold", win_pc, saved_pc);
      chk("stall_win_hold", win_bytes, saved_w);
    end
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 3);
    chk("stall_release_pc", win_pc, saved_pc + 64'd3);
    req_log.delete();
    redir(64'h1000);
    found = 1'b0;
    for (int c = 0; c < 24 && !found; c++) begin
      step(1'b0, 1'b0, '0, 1'b0, 1'b1, 4);
      found = req_log.size() > 0 && req_log[$] == 64'h1010;
    end
    chk("stale_1010_requested", 64'(found), 64'd1);
    redir(64'h2000);
    repeat (3) idle();
    chk("stale_win_pc", win_pc, 64'h2000);
    chk("stale_byte0", 64'(win_bytes[7:0]), 64'h20);
    redir(64'h3000);
    idle();
    idle();
    chk("overlen_pre_cnt", 64'(win_cnt), 64'd4);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 6);
    chk("overlen_win_pc", win_pc, 64'h3000);
    chk("overlen_win_cnt", 64'(win_cnt), 64'd8);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1);
    chk("midrst_win_cnt", 64'(win_cnt), 64'd0);
    chk("midrst_win_bytes", win_bytes, 64'd0);
    chk("midrst_win_pc", win_pc, 64'd0);
    chk("midrst_imem_addr", imem.imem_addr, 64'd0);
    idle();
    chk("midrst_stale_drop", 64'(win_cnt), 64'd0);
    for (int c = 0; c < 1500; c++) begin
      roll = $urandom_range(0, 99);
      rpc = {$urandom, $urandom};
      if (roll == 5) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | reg_t'($urandom_range(0, 15));
      step(roll == 0, roll >= 1 && roll <= 5, rpc, $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 7, $urandom_range(1, 10));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
